// File: rtl/nonce_hub_pkg.sv
// nonce_hub_pkg: shared types, constants and helpers for the nonce collector
package nonce_hub_pkg;
  localparam int NONCE_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} tx_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: single-clock FIFO, read data registered on the cycle after pop
module nonce_fifo
  import nonce_hub_pkg::*;
#(
  parameter int W = NONCE_W_DEF,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // storage array carries no reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and the registered read port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/nonce_hub.sv
// nonce_hub: multi-core golden-nonce collector (NONCE_HUB_TAG_EN adds golden_chan source tag)
module nonce_hub
  import nonce_hub_pkg::*;
#(
  parameter int SLAVES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int ACK_TIMEOUT = 15,
  localparam int CW = clog2(SLAVES) > 0 ? clog2(SLAVES) : 1,
  localparam int CNTW = clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SLAVES-1:0]         ticket,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic                      serial_busy,
  output logic                      serial_send,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic                      new_nonce,
  output logic                      overflow,
  output logic [CNTW-1:0]           fifo_count
`ifdef NONCE_HUB_TAG_EN
  ,
  output logic [CW-1:0]             golden_chan
`endif
);
`ifdef NONCE_HUB_TAG_EN
  localparam int FW = NONCE_W + CW;
`else
  localparam int FW = NONCE_W;
`endif
  localparam int TW = clog2(ACK_TIMEOUT + 1);
  logic [SLAVES-1:0] s1, s2, s3, rise, pend;
  logic [NONCE_W-1:0] pend_nonce [SLAVES];
  logic [CW-1:0] ptr, gnt;
  logic gnt_v, push, pop, full, empty;
  logic [FW-1:0] wr_data, rd_data;
  tx_state_t st;
  logic [TW-1:0] tmo;
  // two-flop synchroniser, then a registered rising-edge pulse per channel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      rise <= '0;
    end else begin
      s1 <= ticket;
      s2 <= s1;
      s3 <= s2;
      rise <= s2 & ~s3;
    end
  // round-robin search starting one past the last granted channel
  always_comb begin
    gnt = '0;
    gnt_v = 1'b0;
    for (int i = 1; i <= SLAVES; i++)
      if (!gnt_v && pend[(int'(ptr) + i) % SLAVES]) begin
        gnt_v = 1'b1;
        gnt = CW'((int'(ptr) + i) % SLAVES);
      end
  end
  assign push = gnt_v && !full;
`ifdef NONCE_HUB_TAG_EN
  assign wr_data = {gnt, pend_nonce[gnt]};
  assign golden_chan = rd_data[FW-1 -: CW];
`else
  assign wr_data = pend_nonce[gnt];
`endif
  assign golden_nonce = rd_data[NONCE_W-1:0];
  // capture nonces on edges; a re-edge on a still-pending channel is lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < SLAVES; i++) pend_nonce[i] <= '0;
      ptr <= CW'(SLAVES - 1);
      overflow <= 1'b0;
      new_nonce <= 1'b0;
    end else begin
      new_nonce <= push;
      if (push) ptr <= gnt;
      for (int i = 0; i < SLAVES; i++)
        if (rise[i] && pend[i] && !(push && gnt == CW'(i))) overflow <= 1'b1;
        else if (rise[i]) begin
          pend[i] <= 1'b1;
          pend_nonce[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
        end else if (push && gnt == CW'(i)) pend[i] <= 1'b0;
    end
  assign pop = st == IDLE && !empty;
  // transmitter handshake: pop, pulse send, wait for busy to rise then fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      serial_send <= 1'b0;
      tmo <= '0;
    end else begin
      serial_send <= 1'b0;
      case (st)
        IDLE: if (!empty) st <= SEND;
        SEND: begin
          serial_send <= 1'b1;
          tmo <= '0;
          st <= ACK;
        end
        ACK:
          if (serial_busy) st <= DRAIN;
          else if (tmo == TW'(ACK_TIMEOUT - 1)) st <= IDLE;
          else tmo <= tmo + 1'b1;
        DRAIN: if (!serial_busy) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  nonce_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wr_data(wr_data),
    .pop(pop),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_nonce_hub.sv
// tb_nonce_hub: directed bench with an ordered-delivery model for nonce_hub
module tb_nonce_hub;
  logic clk = 0, rst = 1, serial_busy = 0;
  logic [3:0] ticket = '0;
  logic [127:0] slave_nonces = '0;
  logic serial_send, new_nonce, overflow;
  logic [31:0] golden_nonce;
  logic [3:0] fifo_count;
`ifdef NONCE_HUB_TAG_EN
  logic [1:0] golden_chan;
`endif
  typedef struct {logic [31:0] n; int c;} exp_t;
  exp_t exp_q[$];
  exp_t ce;
  int total = 0, bad = 0, cyc = 0, bmode = 0, blen = 10, n_sends = 0, peak = 0, rr = 3, saved;
  int send_at[64];
  logic [31:0] sent_val[64];

  nonce_hub dut (
    .clk(clk), .rst(rst), .ticket(ticket), .slave_nonces(slave_nonces),
    .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
    .new_nonce(new_nonce), .overflow(overflow), .fifo_count(fifo_count)
`ifdef NONCE_HUB_TAG_EN
    , .golden_chan(golden_chan)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // transmitter stand-in: 0 = busy for blen after each send, 1 = stuck busy, 2 = never busy
  initial forever begin
    @(negedge clk);
    if (bmode == 1) serial_busy = 1;
    else if (bmode == 2) serial_busy = 0;
    else begin
      serial_busy = 0;
      if (serial_send) begin
        serial_busy = 1;
        repeat (blen) @(negedge clk);
        serial_busy = 0;
      end
    end
  end

  // every send must deliver the next nonce the model expects, in order
  always @(negedge clk) if (!rst) begin
    if (fifo_count > peak) peak = fifo_count;
    chk("count_le_depth", 64'(fifo_count <= 8), 1);
    if (serial_send) begin
      if (n_sends < 64) begin
        send_at[n_sends] = cyc;
        sent_val[n_sends] = golden_nonce;
      end
      n_sends++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: got golden_nonce=%h want no send", golden_nonce);
      end else begin
        ce = exp_q.pop_front();
        chk("send_nonce", golden_nonce, ce.n);
`ifdef NONCE_HUB_TAG_EN
        chk("send_chan", golden_chan, ce.c);
`endif
      end
    end
  end

  // raise tickets of mask together; model queues them round-robin from rr+1
  task automatic fire(input logic [3:0] mask, input logic [127:0] vals, input bit e);
    @(negedge clk);
    for (int c = 0; c < 4; c++) if (mask[c]) slave_nonces[c*32 +: 32] = vals[c*32 +: 32];
    ticket = ticket | mask;
    if (e) begin
      int last;
      last = rr;
      for (int i = 1; i <= 4; i++) if (mask[(rr + i) % 4]) begin
        exp_q.push_back('{vals[((rr + i) % 4)*32 +: 32], (rr + i) % 4});
        last = (rr + i) % 4;
      end
      rr = last;
    end
    repeat (3) @(negedge clk);
    ticket = ticket & ~mask;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unsent after %0d cycles want 0", exp_q.size(), maxc);
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_send", serial_send, 0);
    chk("rst_golden", golden_nonce, 0);
    chk("rst_new", new_nonce, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    // all four channels at once: channel 0 first after reset
    peak = 0;
    fire(4'hF, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1);
    drain(300);
    chk("peak_count", peak, 3);
    chk("order0", sent_val[0], 32'h11111111);
    chk("order1", sent_val[1], 32'h22222222);
    chk("order2", sent_val[2], 32'h33333333);
    chk("order3", sent_val[3], 32'h44444444);
    // single channel latency
    slave_nonces[95:64] = 32'hDEADBEEF;
    @(negedge clk);
    ticket[2] = 1;
    exp_q.push_back('{32'hDEADBEEF, 2});
    rr = 2;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_new_k3", new_nonce, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_new_k4", new_nonce, 1);
    chk("lat_count_k4", fifo_count, 1);
    ticket[2] = 0;
    @(posedge clk);
    @(negedge clk);
    chk("lat_send_k5", serial_send, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_send_k6", serial_send, 1);
    chk("lat_golden", golden_nonce, 32'hDEADBEEF);
    drain(100);
    // transmitter never acknowledges: each send times out after 15 ACK cycles
    bmode = 2;
    fire(4'b0110, {32'h0, 32'hCAFE0002, 32'hCAFE0001, 32'h0}, 1);
    drain(200);
    chk("timeout_gap", send_at[n_sends-1] - send_at[n_sends-2], 17);
    chk("timeout_ch1", sent_val[n_sends-2], 32'hCAFE0001);
    // stuck busy: one in flight, eight buffered, one pending, the next is lost
    bmode = 1;
    for (int i = 1; i <= 10; i++) fire(4'b0001, 128'(i), 1);
    chk("full_count", fifo_count, 8);
    chk("ovf_before", overflow, 0);
    fire(4'b0001, 128'(11), 0);
    chk("ovf_after", overflow, 1);
    bmode = 0;
    drain(400);
    chk("ovf_sticky", overflow, 1);
    chk("empty_after", fifo_count, 0);
    // reset while draining with three queued
    bmode = 1;
    fire(4'hF, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1);
    repeat (4) @(negedge clk);
    chk("pre_rst_count", fifo_count, 3);
    rst = 1;
    exp_q.delete();
    rr = 3;
    saved = n_sends;
    @(negedge clk);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_golden", golden_nonce, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_send", serial_send, 0);
    chk("mid_rst_new", new_nonce, 0);
`ifdef NONCE_HUB_TAG_EN
    chk("mid_rst_chan", golden_chan, 0);
`endif
    rst = 0;
    bmode = 0;
    repeat (40) @(negedge clk);
    chk("post_rst_sends", n_sends, saved);
    chk("post_rst_count", fifo_count, 0);
    // channel 3 alone after reset carries its tag
    fire(4'b1000, {32'h33CC33CC, 96'h0}, 1);
    drain(100);
    chk("ch3_golden", golden_nonce, 32'h33CC33CC);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
